// File: rtl/attack_fsm.sv
// -----------------------------------------------------------------------------
// attack_fsm
//
// Per-player attack sequencer. It turns A (light) and B (heavy) button presses
// into a frame-timed WINDUP -> ACTIVE -> RECOVER sequence. While ACTIVE, it tests
// a hitbox in front of the attacker against the opponent's sprite box. On the
// first overlap it emits a one-cycle hit strobe, raises the opponent's damage
// percent and publishes a knockback vector for the movement FSM.
// One instance is used per player.
//
// Build option:
//   ATTACK_INPUT_BUFFER_EN  when defined, a press during RECOVER is held in a
//                           one-entry buffer. That buffered attack starts WINDUP
//                           on the tick that ends RECOVER. When undefined,
//                           presses outside IDLE are dropped.
//
// Ports:
//   clk              pixel clock
//   rst              synchronous, active-high reset
//   frame_tick       one-cycle pulse per video frame; all phase timing counts these
//   button_A         light attack, level, already synchronised
//   button_B         heavy attack, level, already synchronised
//   facing_right     attacker orientation, selects which side the hitbox sits on
//   self_x, self_y   attacker top-left, screen pixels
//   opp_x, opp_y     opponent top-left, screen pixels
//   attacking        high in WINDUP / ACTIVE / RECOVER
//   anim_row         sprite-sheet row offset (registered)
//   anim_col         sprite-sheet column offset (registered)
//   hit_pulse        one-cycle strobe when an attack connects
//   opp_damage       opponent damage percent, saturating at 999
//   knock_mag        knockback speed for the opponent, 0..63
//   knock_dir_right  knockback direction (attacker orientation at the hit)
// -----------------------------------------------------------------------------
module attack_fsm #(
  parameter int CHAR_W         = 23,
  parameter int CHAR_H         = 30,
  parameter int OPP_W          = 30,
  parameter int OPP_H          = 40,
  parameter int REACH          = 12,
  parameter int WINDUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES  = 3,
  parameter int RECOVER_FRAMES = 8,
  parameter int DMG_LIGHT      = 6,
  parameter int DMG_HEAVY      = 12,
  parameter int ANIM_ROW_BASE  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       button_A,
  input  logic       button_B,
  input  logic       facing_right,
  input  logic [9:0] self_x,
  input  logic [9:0] self_y,
  input  logic [9:0] opp_x,
  input  logic [9:0] opp_y,
  output logic       attacking,
  output logic [9:0] anim_row,
  output logic [9:0] anim_col,
  output logic       hit_pulse,
  output logic [9:0] opp_damage,
  output logic [5:0] knock_mag,
  output logic       knock_dir_right
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDUP  = 2'd1,
    ACTIVE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int CNT_W = 8;

  // Last counter value of each phase; the tick seen at that value ends the phase.
  localparam logic [CNT_W-1:0] LIGHT_WINDUP_LAST = CNT_W'(WINDUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] HEAVY_WINDUP_LAST = CNT_W'(2 * WINDUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST       = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST      = CNT_W'(RECOVER_FRAMES - 1);

  // Sprites are drawn at 2x, so on-screen extents are twice the source size.
  localparam logic [10:0] CHAR_W2 = 11'(2 * CHAR_W);
  localparam logic [10:0] CHAR_H2 = 11'(2 * CHAR_H);
  localparam logic [10:0] OPP_W2  = 11'(2 * OPP_W);
  localparam logic [10:0] OPP_H2  = 11'(2 * OPP_H);
  localparam logic [10:0] REACH11 = 11'(REACH);

  localparam logic [10:0] DMG_MAX   = 11'd999;
  localparam logic [6:0]  KNOCK_MAX = 7'd63;

  localparam logic [9:0] ROW_ATTACK  = 10'(ANIM_ROW_BASE);
  localparam logic [9:0] COL_ACTIVE  = 10'(CHAR_W);
  localparam logic [9:0] COL_RECOVER = 10'(2 * CHAR_W);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             heavy_q, heavy_d;
  logic             landed_q, landed_d;

  logic a_q, b_q;
  logic press_a, press_b, press;

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  // NOTE: the previous-level registers deliberately keep sampling through reset.
  // A button held across reset then produces no edge when reset releases, so it
  // cannot start a spurious attack.
  always_ff @(posedge clk) begin
    a_q <= button_A;
    b_q <= button_B;
  end

  assign press_a = button_A & ~a_q;
  assign press_b = button_B & ~b_q;
  assign press   = press_a | press_b;

  // ---------------------------------------------------------------------------
  // Hitbox and overlap, 11-bit so the right-facing box never wraps
  // ---------------------------------------------------------------------------
  logic [10:0] sx, sy, ox, oy;
  logic [10:0] hb_x_lo, hb_x_hi;
  logic        overlap;
  logic        hit;

  assign sx = {1'b0, self_x};
  assign sy = {1'b0, self_y};
  assign ox = {1'b0, opp_x};
  assign oy = {1'b0, opp_y};

  always_comb begin
    if (facing_right) begin
      hb_x_lo = sx + CHAR_W2;
      hb_x_hi = sx + CHAR_W2 + REACH11;
    end else begin
      // Clamp at the screen edge. At self_x = 0 the box is [0,0), so it is empty.
      hb_x_lo = (sx >= REACH11) ? (sx - REACH11) : 11'd0;
      hb_x_hi = sx;
    end
  end

  // Both boxes are half-open, so an empty hitbox can never overlap anything.
  assign overlap = (hb_x_lo < ox + OPP_W2) && (ox < hb_x_hi) &&
                   (sy < oy + OPP_H2)      && (oy < sy + CHAR_H2);

  assign hit = (state_q == ACTIVE) && overlap && !landed_q;

  // ---------------------------------------------------------------------------
  // Optional one-entry input buffer for presses made during RECOVER
  // ---------------------------------------------------------------------------
`ifdef ATTACK_INPUT_BUFFER_EN
  logic buf_valid_q, buf_valid_d;
  logic buf_heavy_q, buf_heavy_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here is given a default value before the case
  // statement. That way each path assigns every signal and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    heavy_d  = heavy_q;
    landed_d = landed_q;
`ifdef ATTACK_INPUT_BUFFER_EN
    buf_valid_d = buf_valid_q;
    buf_heavy_d = buf_heavy_q;
`endif

    if (hit) landed_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // Leaving IDLE depends only on a press, not on frame_tick. If A and B
        // rise together, press_b makes the attack heavy.
        if (press) begin
          state_d  = WINDUP;
          heavy_d  = press_b;
          cnt_d    = '0;
          landed_d = 1'b0;
        end
      end

      WINDUP: begin
        if (frame_tick) begin
          if (cnt_q == (heavy_q ? HEAVY_WINDUP_LAST : LIGHT_WINDUP_LAST)) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ACTIVE: begin
        if (frame_tick) begin
          if (cnt_q == ACTIVE_LAST) begin
            state_d = RECOVER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RECOVER: begin
`ifdef ATTACK_INPUT_BUFFER_EN
        if (press) begin
          buf_valid_d = 1'b1;
          buf_heavy_d = buf_heavy_q | press_b;  // a heavy press beats a stored light one
        end
`endif
        if (frame_tick) begin
          if (cnt_q == RECOVER_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef ATTACK_INPUT_BUFFER_EN
            // The buffered attack starts on this same tick, skipping IDLE.
            if (buf_valid_d) begin
              state_d     = WINDUP;
              heavy_d     = buf_heavy_d;
              landed_d    = 1'b0;
              buf_valid_d = 1'b0;
              buf_heavy_d = 1'b0;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments. All
  // registers then update together at the clock edge, regardless of the order
  // in which the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      heavy_q  <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      heavy_q  <= heavy_d;
      landed_q <= landed_d;
    end
  end

`ifdef ATTACK_INPUT_BUFFER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_heavy_q <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_heavy_q <= buf_heavy_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Damage and knockback arithmetic for the pending hit
  // ---------------------------------------------------------------------------
  logic [10:0] dmg_sum;
  logic [9:0]  dmg_next;
  logic [6:0]  knock_sum;
  logic [5:0]  knock_next;

  assign dmg_sum  = {1'b0, opp_damage} + (heavy_q ? 11'(DMG_HEAVY) : 11'(DMG_LIGHT));
  assign dmg_next = (dmg_sum > DMG_MAX) ? DMG_MAX[9:0] : dmg_sum[9:0];

  // Knockback uses the damage total after this hit has been added.
  assign knock_sum  = 7'd2 + {1'b0, dmg_next[9:4]} + (heavy_q ? 7'd4 : 7'd0);
  assign knock_next = (knock_sum > KNOCK_MAX) ? KNOCK_MAX[5:0] : knock_sum[5:0];

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  assign attacking = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      anim_row        <= '0;
      anim_col        <= '0;
      hit_pulse       <= 1'b0;
      opp_damage      <= '0;
      knock_mag       <= '0;
      knock_dir_right <= 1'b0;
    end else begin
      // The animation offsets follow the state register one clock later.
      unique case (state_q)
        IDLE: begin
          anim_row <= '0;
          anim_col <= '0;
        end
        WINDUP: begin
          anim_row <= ROW_ATTACK;
          anim_col <= '0;
        end
        ACTIVE: begin
          anim_row <= ROW_ATTACK;
          anim_col <= COL_ACTIVE;
        end
        RECOVER: begin
          anim_row <= ROW_ATTACK;
          anim_col <= COL_RECOVER;
        end
        default: begin
          anim_row <= '0;
          anim_col <= '0;
        end
      endcase

      hit_pulse <= hit;

      // Damage and knockback change only when a hit lands, then hold.
      if (hit) begin
        opp_damage      <= dmg_next;
        knock_mag       <= knock_next;
        knock_dir_right <= facing_right;
      end
    end
  end

endmodule
